// File: rtl/goertzel_power.sv
// Goertzel block-power back end: counts samples, captures filter state at block end,
// and evaluates y1^2 + y2^2 - coef*y1*y2 over a short multi-cycle sequence.
module goertzel_power #(
    parameter int                 W      = 61,
    parameter int                 L      = 205,
    parameter int                 SHIFT  = 16,
    parameter logic signed [31:0] COEF   = 32'h3FFFD69A,
    parameter int                 FRAC   = 29,
    parameter logic [63:0]        THRESH = 64'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic signed [W-1:0] y1,
    input  logic signed [W-1:0] y2,
    output logic                flt_clr,
    output logic                busy,
    output logic [63:0]         power,
    output logic                power_valid,
    output logic                detect
);

    typedef enum logic [2:0] {IDLE, CAP, SQ1, SQ2, XC1, XC2, SUM} state_t;

    localparam int                    WE        = (W > 33) ? W : 33;
    localparam logic signed [WE-1:0]  SAT_MAX   = WE'(64'sd2147483647);
    localparam logic signed [WE-1:0]  SAT_MIN   = WE'(-64'sd2147483648);
    localparam logic [15:0]           LAST      = 16'(L - 1);
    localparam logic signed [63:0]    COEF_EXT  = 64'(COEF);

    state_t               state_q;
    logic [15:0]          cnt_q;
    logic signed [31:0]   a_q, b_q;
    logic signed [63:0]   p1_q, p2_q;
    logic signed [33:0]   c_q;
    logic signed [65:0]   p3_q;
    logic [63:0]          power_q;
    logic                 flt_clr_q, busy_q, power_valid_q, detect_q;

    logic                 e0;
    logic signed [63:0]   a_ext, b_ext;
    logic signed [63:0]   p1_d, p2_d;
    logic signed [33:0]   c_d;
    logic signed [65:0]   p3_d;
    logic signed [66:0]   t_sum;
    logic [63:0]          power_d;

    // Shift first, then clamp into the signed 32-bit range used by the multipliers.
    function automatic logic signed [31:0] sat32(input logic signed [W-1:0] v);
        logic signed [W-1:0]  s;
        logic signed [WE-1:0] e;
        s = v >>> SHIFT;
        e = WE'(s);
        if (e > SAT_MAX)
            return 32'h7FFF_FFFF;
        else if (e < SAT_MIN)
            return 32'h8000_0000;
        else
            return 32'(e);
    endfunction

    assign e0    = sample_en && (cnt_q == LAST);
    assign a_ext = 64'(a_q);
    assign b_ext = 64'(b_q);
    assign p1_d  = a_ext * a_ext;
    assign p2_d  = b_ext * b_ext;
    assign c_d   = 34'((COEF_EXT * a_ext) >>> FRAC);
    assign p3_d  = 66'(c_q) * 66'(b_q);
    assign t_sum = 67'(p1_q) + 67'(p2_q) - 67'(p3_q);

    always_comb begin
        power_d = t_sum[63:0];
        if (t_sum[66])
            power_d = 64'd0;
        else if (t_sum[65:64] != 2'b00)
            power_d = '1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            c_q           <= '0;
            p3_q          <= '0;
            power_q       <= '0;
            flt_clr_q     <= 1'b0;
            busy_q        <= 1'b0;
            power_valid_q <= 1'b0;
            detect_q      <= 1'b0;
        end else begin
            // Counting continues while busy so back-to-back blocks lose no samples.
            if (sample_en)
                cnt_q <= e0 ? 16'd0 : cnt_q + 16'd1;
            flt_clr_q     <= 1'b0;
            power_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= e0;
                    if (e0) begin
                        state_q   <= CAP;
                        flt_clr_q <= 1'b1;
                    end
                end
                CAP: begin
                    a_q     <= sat32(y1);
                    b_q     <= sat32(y2);
                    state_q <= SQ1;
                end
                SQ1: begin
                    p1_q    <= p1_d;
                    state_q <= SQ2;
                end
                SQ2: begin
                    p2_q    <= p2_d;
                    state_q <= XC1;
                end
                XC1: begin
                    c_q     <= c_d;
                    state_q <= XC2;
                end
                XC2: begin
                    p3_q    <= p3_d;
                    state_q <= SUM;
                end
                SUM: begin
                    power_q       <= power_d;
                    detect_q      <= (power_d >= THRESH);
                    power_valid_q <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flt_clr     = flt_clr_q;
    assign busy        = busy_q;
    assign power       = power_q;
    assign power_valid = power_valid_q;
    assign detect      = detect_q;

endmodule

// File: tb/tb_goertzel_power.sv
// Directed bench for goertzel_power: five instances with different COEF/THRESH share
// clock, reset and strobes; each gets its own y1/y2 vectors.
module tb_goertzel_power;

    localparam int N = 5;
    localparam logic [31:0] COEF_TAB [N] = '{32'h0000_0000, 32'h2000_0000, 32'h2000_0000,
                                             32'h6000_0000, 32'hC000_0000};
    localparam logic [63:0] THR_TAB  [N] = '{64'd0, 64'd1000000, 64'd1000001, 64'd0, 64'd0};

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_en;
    logic signed [60:0] y1_s [N];
    logic signed [60:0] y2_s [N];
    wire  [N-1:0]       flt_clr;
    wire  [N-1:0]       busy;
    wire  [N-1:0]       power_valid;
    wire  [N-1:0]       detect;
    wire  [63:0]        power [N];

    logic [63:0] exp_pow [N];
    logic        exp_det [N];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int vcnt     = 0;
    int vstamp [$];

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        goertzel_power #(
            .W(61), .L(8), .SHIFT(0), .COEF(COEF_TAB[gi]), .FRAC(29), .THRESH(THR_TAB[gi])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .sample_en  (sample_en),
            .y1         (y1_s[gi]),
            .y2         (y2_s[gi]),
            .flt_clr    (flt_clr[gi]),
            .busy       (busy[gi]),
            .power      (power[gi]),
            .power_valid(power_valid[gi]),
            .detect     (detect[gi])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (power_valid[0]) begin
            vcnt++;
            vstamp.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            sample_en = 1'b1;
            tick();
        end
        sample_en = 1'b0;
    endtask

    // Entered 1 time unit after E0; watches 10 cycles and scores timing and results.
    task automatic observe(input string name);
        int          clr_at   = -1;
        int          n_clr    = 0;
        int          n_busy   = 0;
        int          valid_at = -1;
        logic [63:0] cp [N];
        logic        cd [N];
        for (int k = 0; k < N; k++) begin
            cp[k] = '1;
            cd[k] = 1'bx;
        end
        for (int j = 0; j < 10; j++) begin
            if (flt_clr[0]) begin
                n_clr++;
                if (clr_at < 0) clr_at = j;
            end
            if (busy[0]) n_busy++;
            if (power_valid[0] && valid_at < 0) begin
                valid_at = j;
                for (int k = 0; k < N; k++) begin
                    cp[k] = power[k];
                    cd[k] = detect[k];
                end
            end
            // Inputs were captured at E1; later changes must not matter.
            if (j == 1) begin
                for (int k = 0; k < N; k++) begin
                    y1_s[k] = 61'h0AAA_5555;
                    y2_s[k] = -61'sh0123_4567;
                end
            end
            tick();
        end
        check($sformatf("%s_clr_at", name), 64'(clr_at), 64'd0);
        check($sformatf("%s_clr_cycles", name), 64'(n_clr), 64'd1);
        check($sformatf("%s_busy_cycles", name), 64'(n_busy), 64'd7);
        check($sformatf("%s_valid_at", name), 64'(valid_at), 64'd6);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_pow%0d", name, k), cp[k], exp_pow[k]);
            check($sformatf("%s_det%0d", name, k), 64'(cd[k]), 64'(exp_det[k]));
        end
        $display("block %s: valid_at=%0d busy=%0d power0=%0d", name, valid_at, n_busy, cp[0]);
    endtask

    task automatic set_vec(input int k, input logic signed [60:0] a, input logic signed [60:0] b,
                           input logic [63:0] p, input logic d);
        y1_s[k]    = a;
        y2_s[k]    = b;
        exp_pow[k] = p;
        exp_det[k] = d;
    endtask

    initial begin
        int v0;
        int n0;
        int gap1;
        int gap2;
        rst       = 1'b0;
        sample_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            y1_s[k] = '0;
            y2_s[k] = '0;
        end
        repeat (3) tick();
        check("rst_power", power[0], 64'd0);
        check("rst_valid", 64'(power_valid[0]), 64'd0);
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_clr", 64'(flt_clr[0]), 64'd0);
        check("rst_detect", 64'(detect[0]), 64'd0);
        rst = 1'b1;
        tick();

        // Block A: basic power, coefficient 1.0 with threshold edges, negative t, coefficient -2.0
        set_vec(0, 61'sd1000, 61'sd0, 64'd1000000, 1'b1);
        set_vec(1, 61'sd1000, 61'sd1000, 64'd1000000, 1'b1);
        set_vec(2, 61'sd1000, 61'sd1000, 64'd1000000, 1'b0);
        set_vec(3, 61'sd100, 61'sd100, 64'd0, 1'b1);
        set_vec(4, -61'sd1000, -61'sd1000, 64'd4000000, 1'b1);
        strobes(8);
        observe("A");
        repeat (3) tick();
        check("A_hold", power[0], 64'd1000000);

        // Block B: positive/negative saturation of a, zero power, small value, 2^64 clamp
        set_vec(0, 61'sh100_0000_0000, 61'sd0, 64'd4611686014132420609, 1'b1);
        set_vec(1, -61'sh100_0000_0000, 61'sd0, 64'd4611686018427387904, 1'b1);
        set_vec(2, 61'sd0, 61'sd0, 64'd0, 1'b0);
        set_vec(3, 61'sd5, 61'sd0, 64'd25, 1'b1);
        set_vec(4, -61'sh100_0000_0000, -61'sh100_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        strobes(8);
        observe("B");

        // Abort in SQ2 (two strobes already counted into the next block), then restart
        set_vec(0, 61'sd5, 61'sd0, 64'd25, 1'b1);
        set_vec(1, 61'sd0, 61'sd0, 64'd0, 1'b0);
        set_vec(2, 61'sd0, 61'sd0, 64'd0, 1'b0);
        set_vec(3, 61'sd0, 61'sd0, 64'd0, 1'b1);
        set_vec(4, 61'sd0, 61'sd0, 64'd0, 1'b1);
        strobes(8);
        sample_en = 1'b1;
        tick();
        tick();
        sample_en = 1'b0;
        rst       = 1'b0;
        v0        = vcnt;
        tick();
        rst = 1'b1;
        check("abort_busy", 64'(busy[0]), 64'd0);
        check("abort_power", power[0], 64'd0);
        repeat (8) tick();
        check("abort_novalid", 64'(vcnt - v0), 64'd0);
        strobes(7);
        repeat (8) tick();
        check("restart_7_novalid", 64'(vcnt - v0), 64'd0);
        strobes(1);
        observe("R");

        // Continuous strobes: three blocks back to back
        y1_s[0] = 61'sd3;
        y2_s[0] = 61'sd0;
        v0 = vcnt;
        n0 = vstamp.size();
        strobes(24);
        repeat (10) tick();
        check("burst_pulses", 64'(vcnt - v0), 64'd3);
        gap1 = -1;
        gap2 = -1;
        if (vstamp.size() >= n0 + 3) begin
            gap1 = vstamp[n0 + 1] - vstamp[n0];
            gap2 = vstamp[n0 + 2] - vstamp[n0 + 1];
        end
        check("burst_gap1", 64'(gap1), 64'd8);
        check("burst_gap2", 64'(gap2), 64'd8);
        check("burst_power", power[0], 64'd9);
        $display("burst: pulses=%0d gaps=%0d,%0d", vcnt - v0, gap1, gap2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/goertzel_power.md
GOERTZEL_POWER -- requirements
Module: goertzel_power

Interface
REQ-001 Parameter W, default 61: width of signed filter state inputs y1/y2.
REQ-002 Parameter L, default 205: samples per analysis block; legal range 8..65535.
REQ-003 Parameter SHIFT, default 16: arithmetic right shift applied to y1/y2 before power arithmetic.
REQ-004 Parameter COEF, default 32'h3FFFD69A: signed 32-bit coefficient 2cos(w) in fixed point.
REQ-005 Parameter FRAC, default 29: fractional bits of COEF.
REQ-006 Parameter THRESH, default 64'd0: unsigned tone-detect threshold.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 sample_en  in  1  one-cycle strobe per input sample consumed by the upstream Goertzel filter.
REQ-010 y1  in  W  signed filter state s[n-1].
REQ-011 y2  in  W  signed filter state s[n-2].
REQ-012 flt_clr  out  1  one-cycle request to clear upstream filter state at block end.
REQ-013 busy  out  1  high while a power computation is in progress.
REQ-014 power  out  64  unsigned block power estimate, held between updates.
REQ-015 power_valid  out  1  one-cycle strobe: power updated.
REQ-016 detect  out  1  power >= THRESH, updated with power_valid, held otherwise.

Function
REQ-017 Sample counter SHALL count sample_en strobes 0..L-1 and wrap to 0 on the edge sampling the L-th strobe (edge E0).
REQ-018 Counter SHALL keep counting during busy, so the next block is not delayed.
REQ-019 FSM states IDLE, CAP, SQ1, SQ2, XC1, XC2, SUM; IDLE->CAP at E0, then one state per cycle, SUM->IDLE.
REQ-020 In CAP, flt_clr=1 for exactly that cycle; at E1, a = sat32(y1 >>> SHIFT) and b = sat32(y2 >>> SHIFT) SHALL be registered.
REQ-021 sat32: values above 2^31-1 clamp to 2^31-1; values below -2^31 clamp to -2^31.
REQ-022 E2: p1 = a*a (64-bit); E3: p2 = b*b; E4: c = (COEF*a) >>> FRAC, truncated to 34-bit signed; E5: p3 = c*b (66-bit signed).
REQ-023 E6 (SUM): t = p1 + p2 - p3 in 67-bit signed; t<0 -> power=0; t>2^64-1 -> power=2^64-1; else power=t.
REQ-024 power_valid SHALL be high in the cycle after E6, i.e. 6 clocks after E0; detect updates at the same edge.
REQ-025 busy SHALL be high from the cycle after E0 through the power_valid cycle inclusive (7 cycles).
REQ-026 A block end cannot occur while busy (L>=8); no overrun handling is required.
REQ-027 sample_en coinciding with E0 SHALL be counted as the L-th sample of the current block, never the first of the next.
REQ-028 y1/y2 SHALL be sampled only at E1; changes at other times SHALL have no effect.

Reset
REQ-029 While rst=0 at a clock edge: counter=0, state=IDLE, a=b=0, all products 0, power=0, power_valid=0, detect=0, flt_clr=0, busy=0.
REQ-030 Reset during any non-IDLE state SHALL abort the computation with no power_valid and no power/detect update.
REQ-031 After rst returns to 1, the first block SHALL end on the L-th subsequent sample_en.

Verification (L=8, SHIFT=0, FRAC=29 unless stated)
REQ-032 COEF=0, y1=1000, y2=0, 8 strobes -> flt_clr 1 cycle after E0; power_valid 6 cycles after E0; power=1000000; busy high 7 cycles.
REQ-033 COEF=2^29 (1.0), y1=y2=1000 -> power=1000000; THRESH=1000000 -> detect=1; THRESH=1000001 -> detect=0.
REQ-034 COEF=3*2^29, y1=y2=100 -> t=-10000 -> power=0, detect follows THRESH=0 -> 1.
REQ-035 y1=2^40 (W=61), y2=0, COEF=0 -> a saturates to 2^31-1 -> power=(2^31-1)^2=4611686014132420609.
REQ-036 rst=0 asserted during SQ2, released, y1=5, COEF=0 -> no power_valid for the aborted block; next power_valid after 8 new strobes, power=25.
REQ-037 sample_en every cycle for 24 cycles -> exactly 3 power_valid pulses, spaced 8 cycles apart; counter never skips a sample.
